frame_reader: RTL and testbench
===============================

# frame_reader

Scan-out stage between the VGA timing generator and `color_mapper`. Fetches the 1-bit-per-pixel framebuffer from synchronous on-chip RAM and delivers `is_pixel` with matching `ReadX`/`ReadY` for each displayed pixel. Owns front/back buffer selection and performs renderer-requested buffer swaps only at the start of vertical sync.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line (multiple of 32)
- V_ACTIVE, 480, active lines per frame
- WORDS_PER_LINE, 20, H_ACTIVE/32
- BUF_WORDS, 9600, words per buffer (WORDS_PER_LINE*V_ACTIVE)

Ports:
- Clk  in  1  system clock; the only clock
- Reset_n  in  1  asynchronous, active-low reset
- pix_en  in  1  one-cycle strobe per pixel (Clk/2 rate from VGA controller)
- DrawX, DrawY  in  10 each  current scan coordinates, valid when pix_en=1
- VGA_VS  in  1  vertical sync, active low, synchronous to Clk
- fb_rd_en  out  1  RAM read enable
- fb_rd_addr  out  15  RAM word address
- fb_rd_data  in  32  RAM read data, valid exactly 1 Clk after fb_rd_en
- is_pixel  out  1  pixel lit (to color_mapper)
- ReadX, ReadY  out  10 each  coordinates belonging to is_pixel
- out_valid  out  1  one-cycle strobe: is_pixel/ReadX/ReadY updated
- swap_req  in  1  level request from renderer: back buffer complete
- swap_ack  out  1  one-cycle pulse: swap done
- front_sel  out  1  buffer currently scanned out; renderer writes to ~front_sel

## Operation
- Memory map: buffer b occupies words [b*BUF_WORDS, b*BUF_WORDS+BUF_WORDS-1]. Pixel (x,y) = bit x[4:0] of word b*9600 + y*20 + x[9:5]. Bit 0 = leftmost pixel of word. y*20 computed as (y<<4)+(y<<2); 15-bit result, no wrap for legal coordinates.
- Active pixel: DrawX<640 and DrawY<480. Outside active area: no read issued, is_pixel=0, out_valid still pulses with the coordinates.
- Pipeline (per pix_en): S0 registers DrawX, DrawY, active flag, front_sel snapshot and address. Read issued when active and DrawX[4:0]==0. S1 RAM access. S2 on read return, word register loads fb_rd_data; is_pixel = active & word[ReadX[4:0]] (for the fetch pixel, bit taken from incoming data directly). Non-fetch pixels reuse the held word.
- Swap FSM states: IDLE, ARMED, ACK.
  - IDLE: swap_req=1 -> ARMED.
  - ARMED: falling edge of VGA_VS (prev=1, now=0) -> toggle front_sel, go ACK.
  - ACK: swap_ack=1 for this cycle, -> IDLE unconditionally.
  - Renderer must drop swap_req within the frame after the ack; if still high in IDLE, a further swap arms (second swap at next VS edge). That is defined behaviour, not an error.
  - swap_req dropping while ARMED: stay ARMED (request is committed).
- front_sel snapshot per pixel at S0; a toggle never affects pixels already in flight.

## Timing
- Reset (async assert, sync-free release): is_pixel=0, ReadX=ReadY=0, out_valid=0, fb_rd_en=0, fb_rd_addr=0, swap_ack=0, front_sel=0, FSM=IDLE, word register=0, VS edge history=1 (no false edge after reset).
- Latency: pix_en at cycle t -> fb_rd_en/fb_rd_addr at t+1 -> fb_rd_data at t+2 -> out_valid, is_pixel, ReadX/ReadY at t+3. Fixed, independent of active/fetch status.
- Throughput: sustains pix_en every cycle; pix_en gaps insert no bubbles beyond gaps.
- fb_rd_en high exactly one cycle per fetch; 20 reads per active line, 9600 per frame.
- VS edge and swap_ack: front_sel toggles the cycle after the edge is seen; swap_ack high the following cycle, front_sel already at new value.
- Reset mid-line: pipeline flushed, no out_valid until 3 cycles after next pix_en; first pixel of resumed line with DrawX[4:0]!=0 reads held word 0 -> is_pixel=0 until next fetch.

## Test plan
- Word 0 = 32'h0000_0005, front_sel=0, scan (0..3,0) -> fb_rd_addr=0 at x=0 only; is_pixel = 1,0,1,0; out_valid 3 cycles after each pix_en.
- Addressing: pix (32,1) front 0 -> addr 21; after swap, pix (608,479) -> addr 9600+9580+19=19199.
- Blanking: DrawX=700, DrawY=10 and DrawX=5, DrawY=500 -> no fb_rd_en, is_pixel=0, out_valid=1, ReadX/ReadY echoed.
- Swap: swap_req=1 mid-frame, VGA_VS falls at cycle n -> front_sel 0->1 at n+1, swap_ack pulse n+2; no second swap while swap_req low; swap_req held high -> second toggle at next VS fall.
- Reset_n pulse while ARMED and pipeline full -> all outputs at reset values immediately, front_sel=0, no swap_ack on subsequent VS edge unless swap_req reasserted.
- Back-to-back pix_en every cycle across a full line -> 640 out_valid pulses, 20 reads, pixel order and bit values match reference model.

Source files
------------

// File: rtl/frame_reader.sv
// -----------------------------------------------------------------------------
// frame_reader
//
// Scan-out stage between the VGA timing generator and color_mapper. For each
// pix_en strobe it fetches (when needed) one 32-bit word of the 1-bpp
// framebuffer from synchronous RAM and emits is_pixel with the coordinates it
// belongs to, a fixed three cycles after the strobe. It also owns the
// front/back buffer selection and swaps buffers on request, only at the
// falling edge of vertical sync.
//
// Ports:
//   Clk          system clock (only clock)
//   Reset_n      asynchronous active-low reset
//   pix_en       one-cycle strobe per pixel; DrawX/DrawY valid with it
//   DrawX/DrawY  current scan coordinates
//   VGA_VS       vertical sync, active low, synchronous to Clk
//   fb_rd_en     RAM read enable (one cycle per fetched word)
//   fb_rd_addr   RAM word address
//   fb_rd_data   RAM read data, valid one Clk after fb_rd_en
//   is_pixel     pixel lit
//   ReadX/ReadY  coordinates belonging to is_pixel
//   out_valid    one-cycle strobe: is_pixel/ReadX/ReadY updated
//   swap_req     level request from renderer: back buffer complete
//   swap_ack     one-cycle pulse: swap done
//   front_sel    buffer being scanned out; renderer draws into ~front_sel
// -----------------------------------------------------------------------------
module frame_reader #(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int WORDS_PER_LINE = 20,
  parameter int BUF_WORDS      = 9600
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        pix_en,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        VGA_VS,
  output logic        fb_rd_en,
  output logic [14:0] fb_rd_addr,
  input  logic [31:0] fb_rd_data,
  output logic        is_pixel,
  output logic [9:0]  ReadX,
  output logic [9:0]  ReadY,
  output logic        out_valid,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        front_sel
);

  localparam logic [9:0]  H_LIM    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_LIM    = 10'(V_ACTIVE);
  localparam logic [14:0] BUF_BASE = 15'(BUF_WORDS);

  typedef enum logic [1:0] {
    SW_IDLE,
    SW_ARMED,
    SW_ACK
  } swap_state_t;

  // ---------------------------------------------------------------------------
  // Address generation for the incoming pixel
  // ---------------------------------------------------------------------------
  logic        active_in;
  logic        fetch_in;
  logic [14:0] line_base;
  logic [14:0] addr_in;

  assign active_in = (DrawX < H_LIM) && (DrawY < V_LIM);
  // A new word is needed only at the first pixel of each 32-pixel group.
  assign fetch_in  = active_in && (DrawX[4:0] == 5'd0);

  generate
    if (WORDS_PER_LINE == 20) begin : g_line_shift
      // y*20 as (y<<4)+(y<<2); fits in 15 bits for any legal line.
      assign line_base = ({5'd0, DrawY} << 4) + ({5'd0, DrawY} << 2);
    end else begin : g_line_mult
      assign line_base = {5'd0, DrawY} * 15'(WORDS_PER_LINE);
    end
  endgenerate

  assign addr_in = (front_sel ? BUF_BASE : 15'd0) + line_base + {10'd0, DrawX[9:5]};

  // ---------------------------------------------------------------------------
  // Pixel pipeline: S0 (issue) -> S1 (RAM access) -> output register
  // ---------------------------------------------------------------------------
  logic        s0_valid_reg;
  logic [9:0]  s0_x_reg;
  logic [9:0]  s0_y_reg;
  logic        s0_active_reg;
  logic        s1_valid_reg;
  logic [9:0]  s1_x_reg;
  logic [9:0]  s1_y_reg;
  logic        s1_active_reg;
  logic        s1_fetch_reg;
  logic [31:0] word_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s0_valid_reg  <= 1'b0;
      s0_x_reg      <= 10'd0;
      s0_y_reg      <= 10'd0;
      s0_active_reg <= 1'b0;
      fb_rd_en      <= 1'b0;
      fb_rd_addr    <= 15'd0;
      s1_valid_reg  <= 1'b0;
      s1_x_reg      <= 10'd0;
      s1_y_reg      <= 10'd0;
      s1_active_reg <= 1'b0;
      s1_fetch_reg  <= 1'b0;
      word_reg      <= 32'd0;
      out_valid     <= 1'b0;
      is_pixel      <= 1'b0;
      ReadX         <= 10'd0;
      ReadY         <= 10'd0;
    end else begin
      // S0: capture the pixel; front_sel is sampled here so a later swap
      // cannot affect pixels already in flight.
      s0_valid_reg <= pix_en;
      fb_rd_en     <= pix_en && fetch_in;
      if (pix_en) begin
        s0_x_reg      <= DrawX;
        s0_y_reg      <= DrawY;
        s0_active_reg <= active_in;
        if (fetch_in) begin
          fb_rd_addr <= addr_in;
        end
      end

      // S1: RAM is reading; carry the pixel's context alongside.
      s1_valid_reg <= s0_valid_reg;
      s1_fetch_reg <= fb_rd_en;
      if (s0_valid_reg) begin
        s1_x_reg      <= s0_x_reg;
        s1_y_reg      <= s0_y_reg;
        s1_active_reg <= s0_active_reg;
      end

      // Output: the fetch pixel takes its bit straight from the returning
      // data, the rest of the group from the held word.
      out_valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        ReadX <= s1_x_reg;
        ReadY <= s1_y_reg;
        if (s1_fetch_reg) begin
          word_reg <= fb_rd_data;
          is_pixel <= s1_active_reg && fb_rd_data[s1_x_reg[4:0]];
        end else begin
          is_pixel <= s1_active_reg && word_reg[s1_x_reg[4:0]];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer swap FSM
  // ---------------------------------------------------------------------------
  swap_state_t swap_state_reg;
  logic        vs_prev_reg;
  logic        vs_fall;

  // History resets high so a low VGA_VS right after reset is not an edge.
  assign vs_fall = vs_prev_reg && !VGA_VS;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      swap_state_reg <= SW_IDLE;
      vs_prev_reg    <= 1'b1;
      front_sel      <= 1'b0;
      swap_ack       <= 1'b0;
    end else begin
      vs_prev_reg <= VGA_VS;
      swap_ack    <= 1'b0;
      case (swap_state_reg)
        SW_IDLE: begin
          if (swap_req) begin
            swap_state_reg <= SW_ARMED;
          end
        end
        SW_ARMED: begin
          // Once armed the request is committed even if swap_req drops.
          if (vs_fall) begin
            front_sel      <= ~front_sel;
            swap_state_reg <= SW_ACK;
          end
        end
        SW_ACK: begin
          swap_ack       <= 1'b1;
          swap_state_reg <= SW_IDLE;
        end
        default: begin
          swap_state_reg <= SW_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_frame_reader
//
// Directed bench for frame_reader. A behavioural synchronous RAM (one cycle
// read latency) backs the framebuffer; a negedge monitor records every
// out_valid and fb_rd_en event with a cycle stamp, and directed sequences
// compare those records against hand-computed values.
// -----------------------------------------------------------------------------
module tb_frame_reader;

  logic        clk;
  logic        rst_n;
  logic        pix_en;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic        vga_vs;
  logic        fb_rd_en;
  logic [14:0] fb_rd_addr;
  logic [31:0] fb_rd_data;
  logic        is_pixel;
  logic [9:0]  read_x;
  logic [9:0]  read_y;
  logic        out_valid;
  logic        swap_req;
  logic        swap_ack;
  logic        front_sel;

  frame_reader dut (
    .Clk        (clk),
    .Reset_n    (rst_n),
    .pix_en     (pix_en),
    .DrawX      (draw_x),
    .DrawY      (draw_y),
    .VGA_VS     (vga_vs),
    .fb_rd_en   (fb_rd_en),
    .fb_rd_addr (fb_rd_addr),
    .fb_rd_data (fb_rd_data),
    .is_pixel   (is_pixel),
    .ReadX      (read_x),
    .ReadY      (read_y),
    .out_valid  (out_valid),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .front_sel  (front_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Framebuffer RAM model: registered read.
  logic [31:0] mem [0:19199];
  initial fb_rd_data = 32'd0;
  always @(posedge clk) begin
    if (fb_rd_en) fb_rd_data <= mem[fb_rd_addr];
  end

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       pix;
    int         cyc;
  } ov_t;

  typedef struct {
    logic [14:0] addr;
    int          cyc;
  } rd_t;

  ov_t ov_q[$];
  rd_t rd_q[$];
  int  drv_q[$];
  int  ack_cnt = 0;
  ov_t ov_e;
  rd_t rd_e;

  always @(negedge clk) begin
    if (out_valid) begin
      ov_e.x   = read_x;
      ov_e.y   = read_y;
      ov_e.pix = is_pixel;
      ov_e.cyc = cyc;
      ov_q.push_back(ov_e);
    end
    if (fb_rd_en) begin
      rd_e.addr = fb_rd_addr;
      rd_e.cyc  = cyc;
      rd_q.push_back(rd_e);
    end
    if (swap_ack) ack_cnt = ack_cnt + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int x, input int y);
    @(negedge clk);
    pix_en = 1'b1;
    draw_x = 10'(x);
    draw_y = 10'(y);
    drv_q.push_back(cyc);
    $display("drive pixel x=%0d y=%0d cyc=%0d front_sel=%0d", x, y, cyc, front_sel);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_en = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic clear_q();
    @(posedge clk);
    ov_q.delete();
    rd_q.delete();
    drv_q.delete();
  endtask

  task automatic vs_pulse();
    @(negedge clk);
    vga_vs = 1'b0;
    repeat (4) @(negedge clk);
    vga_vs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  int          n0;
  int          ack_base;
  logic [31:0] w;

  initial begin
    for (int i = 0; i < 19200; i++) mem[i] = 32'd0;
    mem[0]     = 32'h0000_0005;
    mem[21]    = 32'h0000_0001;
    mem[9620]  = 32'h0000_0005;
    mem[19199] = 32'h0000_0001;
    for (int i = 60; i < 80; i++) mem[i] = $urandom;

    rst_n    = 1'b0;
    pix_en   = 1'b0;
    draw_x   = 10'd0;
    draw_y   = 10'd0;
    vga_vs   = 1'b1;
    swap_req = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_is_pixel",  is_pixel,   0);
    check("rst_out_valid", out_valid,  0);
    check("rst_rd_en",     fb_rd_en,   0);
    check("rst_rd_addr",   fb_rd_addr, 0);
    check("rst_read_x",    read_x,     0);
    check("rst_read_y",    read_y,     0);
    check("rst_swap_ack",  swap_ack,   0);
    check("rst_front_sel", front_sel,  0);
    rst_n = 1'b1;
    idle(2);
    clear_q();

    // Word 0 = 5: pixels 0..3 of line 0 -> 1,0,1,0, one read at x=0
    for (int i = 0; i < 4; i++) drive(i, 0);
    idle(6);
    check("t1_ov_count", ov_q.size(), 4);
    check("t1_rd_count", rd_q.size(), 1);
    if (rd_q.size() == 1) begin
      check("t1_rd_addr", rd_q[0].addr, 0);
      check("t1_rd_lat",  rd_q[0].cyc - drv_q[0], 1);
    end
    if (ov_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t1_x",   ov_q[i].x, i);
        check("t1_pix", ov_q[i].pix, (i % 2 == 0) ? 1 : 0);
        check("t1_lat", ov_q[i].cyc - drv_q[i], 3);
      end
    end
    clear_q();

    // Addressing: (32,1) front 0 -> word 21
    drive(32, 1);
    idle(6);
    check("t2_rd_count", rd_q.size(), 1);
    if (rd_q.size() == 1) check("t2_rd_addr", rd_q[0].addr, 21);
    check("t2_ov_count", ov_q.size(), 1);
    if (ov_q.size() == 1) check("t2_pix", ov_q[0].pix, 1);
    clear_q();

    // Blanking: no reads, is_pixel 0, coordinates echoed
    drive(700, 10);
    drive(5, 500);
    idle(6);
    check("t3_rd_count", rd_q.size(), 0);
    check("t3_ov_count", ov_q.size(), 2);
    if (ov_q.size() == 2) begin
      check("t3_x0",   ov_q[0].x, 700);
      check("t3_y0",   ov_q[0].y, 10);
      check("t3_pix0", ov_q[0].pix, 0);
      check("t3_x1",   ov_q[1].x, 5);
      check("t3_y1",   ov_q[1].y, 500);
      check("t3_pix1", ov_q[1].pix, 0);
    end
    clear_q();

    // Swap: arm mid-frame, VS falls at cycle n
    ack_base = ack_cnt;
    @(negedge clk);
    swap_req = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_armed_sel", front_sel, 0);
    @(negedge clk);
    vga_vs = 1'b0;
    n0 = cyc;
    @(negedge clk);
    check("t4_sel_n1", front_sel, 1);
    check("t4_ack_n1", swap_ack, 0);
    check("t4_cyc_n1", cyc - n0, 1);
    swap_req = 1'b0;
    @(negedge clk);
    check("t4_ack_n2", swap_ack, 1);
    check("t4_sel_n2", front_sel, 1);
    @(negedge clk);
    check("t4_ack_n3", swap_ack, 0);
    vga_vs = 1'b1;
    repeat (3) @(negedge clk);
    vs_pulse();
    check("t4_no_second_sel", front_sel, 1);
    check("t4_ack_total", ack_cnt - ack_base, 1);

    // Addressing after swap: (608,479) -> 9600+9580+19
    clear_q();
    drive(608, 479);
    idle(6);
    check("t5_rd_count", rd_q.size(), 1);
    if (rd_q.size() == 1) check("t5_rd_addr", rd_q[0].addr, 19199);
    check("t5_ov_count", ov_q.size(), 1);
    if (ov_q.size() == 1) check("t5_pix", ov_q[0].pix, 1);

    // swap_req held high: toggle at each VS fall
    ack_base = ack_cnt;
    @(negedge clk);
    swap_req = 1'b1;
    repeat (2) @(negedge clk);
    vs_pulse();
    check("t6_sel_first", front_sel, 0);
    vs_pulse();
    check("t6_sel_second", front_sel, 1);
    check("t6_ack_total", ack_cnt - ack_base, 2);
    // Still high after the second ack, so the FSM is armed again.
    @(negedge clk);
    swap_req = 1'b0;

    // Reset while armed with the pipeline full (front 1, line 1 -> word 9620)
    clear_q();
    for (int i = 0; i < 6; i++) drive(i, 1);
    @(negedge clk);
    pix_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("t7_out_valid", out_valid,  0);
    check("t7_rd_en",     fb_rd_en,   0);
    check("t7_rd_addr",   fb_rd_addr, 0);
    check("t7_read_x",    read_x,     0);
    check("t7_read_y",    read_y,     0);
    check("t7_is_pixel",  is_pixel,   0);
    check("t7_front_sel", front_sel,  0);
    check("t7_swap_ack",  swap_ack,   0);
    clear_q();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    check("t7_flush_ov", ov_q.size(), 0);
    check("t7_flush_rd", rd_q.size(), 0);
    ack_base = ack_cnt;
    vs_pulse();
    check("t7_no_ack",      ack_cnt - ack_base, 0);
    check("t7_sel_after",   front_sel, 0);
    // Resumed mid-group: held word is cleared, so bit 2 reads as 0.
    clear_q();
    drive(2, 1);
    idle(6);
    check("t7_resume_rd", rd_q.size(), 0);
    check("t7_resume_ov", ov_q.size(), 1);
    if (ov_q.size() == 1) begin
      check("t7_resume_x",   ov_q[0].x, 2);
      check("t7_resume_pix", ov_q[0].pix, 0);
      check("t7_resume_lat", ov_q[0].cyc - drv_q[0], 3);
    end
    clear_q();

    // Full line back-to-back, line 3 (words 60..79)
    for (int i = 0; i < 640; i++) drive(i, 3);
    idle(6);
    check("t8_ov_count", ov_q.size(), 640);
    check("t8_rd_count", rd_q.size(), 20);
    if (rd_q.size() == 20) begin
      for (int k = 0; k < 20; k++) check("t8_rd_addr", rd_q[k].addr, 60 + k);
    end
    if (ov_q.size() == 640) begin
      for (int i = 0; i < 640; i++) begin
        w = mem[60 + i / 32];
        check("t8_x",   ov_q[i].x, i);
        check("t8_pix", ov_q[i].pix, (w >> (i % 32)) & 32'd1);
        check("t8_lat", ov_q[i].cyc - drv_q[i], 3);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
